ps2_scan_receiver: RTL and testbench
====================================

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, consecutive equal ps2c samples needed to change filtered clock level.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, scancode FIFO entries, power of two, >=2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a filtered falling edge before a partial frame is aborted.
REQ-004 SHALL have ports: clk  in  1  system clock (one clock, all logic on rising edge).
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 EN  in  1  receive enable; low aborts/blocks reception.
REQ-007 ps2d, ps2c  in  1 each  raw PS/2 data and clock lines.
REQ-008 rd_en  in  1  pop FIFO head when out_valid.
REQ-009 dato  out  8  FIFO head scancode; out_brk, out_ext  out  1 each  head flags.
REQ-010 out_valid  out  1  FIFO non-empty; tick  out  1  one-cycle pulse per accepted frame.
REQ-011 correct  out  1  last completed frame passed parity and stop checks.
REQ-012 frame_err, overflow  out  1 each  sticky error flags; fill  out  $clog2(FIFO_DEPTH)+1  entry count.

Function
REQ-013 SHALL double-register ps2c and ps2d, then filter ps2c per FILTER_LEN; falling edge of filtered clock = one-cycle event fe.
REQ-014 SHALL implement FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing only on fe.
REQ-015 In IDLE, fe with ps2d=0 SHALL enter DATA; fe with ps2d=1 SHALL be ignored.
REQ-016 Parity SHALL be odd over 8 data bits plus parity bit; stop bit SHALL be 1.
REQ-017 On fe in STOP: good parity and stop -> correct=1, byte to decoder; otherwise correct=0, frame_err=1, byte dropped.
REQ-018 Non-IDLE state with TIMEOUT_CYCLES cycles without fe SHALL return to IDLE, set frame_err, push nothing; correct unchanged.
REQ-019 EN=0 SHALL force IDLE the next cycle, discard any partial frame, no flags set; FIFO remains readable.
REQ-020 Accepted data byte SHALL be pushed in the cycle after the stop-bit fe; tick pulses that same cycle; out_valid high the following cycle if FIFO was empty.
REQ-021 FIFO SHALL be first-word-fall-through: dato/out_brk/out_ext show head whenever out_valid=1.
REQ-022 rd_en while empty SHALL be ignored; push while full without same-cycle pop SHALL be dropped and set overflow.
REQ-023 Simultaneous push and pop SHALL both succeed at any fill, including full, fill unchanged.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; fill SHALL range 0..FIFO_DEPTH.

Reset
REQ-025 rst=0 at a clk edge SHALL set FSM=IDLE, bit counter=0, filter to 1s, prefix flags=0, FIFO empty, fill=0, dato=0, out_valid=0, tick=0, correct=1, frame_err=0, overflow=0.
REQ-026 Reset mid-frame SHALL discard the frame; the next frame starts cleanly after release.

Configuration
REQ-027 With PS2_EXT_DECODE_EN defined: accepted 8'hE0 sets pending ext, 8'hF0 sets pending brk, neither pushed nor ticked; next other byte is pushed with pending flags, then flags clear.
REQ-028 Without PS2_EXT_DECODE_EN: every accepted byte pushed raw and ticked; out_brk=out_ext=0 constantly.

Structure
REQ-029 Shared package ps2_pkg SHALL hold FSM state typedef, PS2_EXT_CODE=8'hE0, PS2_BRK_CODE=8'hF0, PS2_FRAME_BITS=11.
REQ-030 FIFO SHALL be sub-module ps2_sync_fifo (width 10: {ext,brk,code}), parametrised by depth.

Verification
REQ-031 Frame 0x1C, odd parity 0, stop 1 -> tick once, dato=0x1C, out_valid=1, correct=1, fill=1.
REQ-032 PS2_EXT_DECODE_EN, frames E0,F0,75 -> single tick, dato=0x75, out_ext=1, out_brk=1; without macro -> three ticks, three raw entries.
REQ-033 Frame 0x1C with parity bit 1 -> no tick, correct=0, frame_err=1, fill=0.
REQ-034 FIFO_DEPTH=8, 9 frames without rd_en -> fill=8, overflow=1, first 8 codes pop in order; push and rd_en same cycle at fill=8 -> fill stays 8.
REQ-035 Stop clock after 4 data bits for TIMEOUT_CYCLES -> frame_err=1, IDLE; next full frame 0x2A accepted normally.
REQ-036 EN=0 mid-frame then EN=1 -> no push, no error flags; glitch on ps2c shorter than FILTER_LEN cycles -> no bit sampled.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and PS/2 frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: first-word-fall-through FIFO with sticky overflow on dropped pushes
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop, full;
  assign valid = fill != '0;
  assign full = fill == (AW+1)'(DEPTH);
  assign do_pop = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= overflow || (push && full && !do_pop);
    end
  end
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: filtered PS/2 frame receiver feeding a scancode FIFO
// Define PS2_EXT_DECODE_EN to fold E0/F0 prefixes into the ext/brk flags of the next byte.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          EN,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rd_en,
  output logic [7:0]                    dato,
  output logic                          out_brk,
  output logic                          out_ext,
  output logic                          out_valid,
  output logic                          tick,
  output logic                          correct,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] c_s, d_s;
  logic [FILTER_LEN-1:0] filt;
  logic f_lvl, fe, d;
  ps2_state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, code;
  logic par, par_n, done, bad, timeout, acc, push;
  logic [TW-1:0] tmr, tmr_n;
  logic [9:0] push_data, head;
  assign d = d_s[1];
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_s <= 2'b11;
      d_s <= 2'b11;
      filt <= '1;
      f_lvl <= 1'b1;
      fe <= 1'b0;
    end else begin
      c_s <= {c_s[0], ps2c};
      d_s <= {d_s[0], ps2d};
      filt <= {filt[FILTER_LEN-2:0], c_s[1]};
      f_lvl <= &filt ? 1'b1 : ~|filt ? 1'b0 : f_lvl;
      fe <= f_lvl && ~|filt;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    par_n = par;
    done = 1'b0;
    bad = 1'b0;
    timeout = 1'b0;
    tmr_n = (state == IDLE || fe) ? '0 : tmr + 1'b1;
    if (!EN) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state != IDLE && !fe && tmr == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      cnt_n = '0;
      timeout = 1'b1;
    end else if (fe) begin
      case (state)
        IDLE: begin
          state_n = d ? IDLE : DATA;
          cnt_n = '0;
        end
        DATA: begin
          sh_n = {d, sh[7:1]};
          cnt_n = cnt + 3'd1;
          state_n = cnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_n = d;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          done = d && ^{sh, par};
          bad = !done;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tmr <= '0;
      acc <= 1'b0;
      code <= '0;
      correct <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      par <= par_n;
      tmr <= tmr_n;
      acc <= done;
      code <= done ? sh : code;
      correct <= done ? 1'b1 : bad ? 1'b0 : correct;
      frame_err <= frame_err || bad || timeout;
    end
  end
`ifdef PS2_EXT_DECODE_EN
  logic pend_ext, pend_brk, is_ext, is_brk;
  assign is_ext = code == PS2_EXT_CODE;
  assign is_brk = code == PS2_BRK_CODE;
  assign push = acc && !is_ext && !is_brk;
  assign push_data = {pend_ext, pend_brk, code};
  always_ff @(posedge clk) begin
    if (!rst || push) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (acc) begin
      pend_ext <= pend_ext || is_ext;
      pend_brk <= pend_brk || is_brk;
    end
  end
`else
  assign push = acc;
  assign push_data = {2'b00, code};
`endif
  assign tick = push;
  assign {out_ext, out_brk, dato} = head;
  ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(push_data),
    .pop(rd_en),
    .dout(head),
    .valid(out_valid),
    .fill(fill),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: scoreboard bench driving directed PS/2 frames
`timescale 1ns/1ps
module tb_ps2_scan_receiver;
  import ps2_pkg::*;
  localparam int TO = 2000;
  localparam int HALF = 20;
  logic clk = 1'b0, rst = 1'b0, EN = 1'b1, ps2d = 1'b1, ps2c = 1'b1, rd_en = 1'b0;
  logic [7:0] dato;
  logic out_brk, out_ext, out_valid, tick, correct, frame_err, overflow;
  logic [3:0] fill;
  logic [9:0] q[$];
  int n_pass = 0, n_tot = 0, ticks = 0, t0;
  bit auto_rd = 1'b0, tick_rd = 1'b0;

  ps2_scan_receiver #(.FILTER_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .EN(EN), .ps2d(ps2d), .ps2c(ps2c), .rd_en(rd_en),
    .dato(dato), .out_brk(out_brk), .out_ext(out_ext), .out_valid(out_valid),
    .tick(tick), .correct(correct), .frame_err(frame_err), .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(negedge clk);
    if (tick) ticks++;
    if (out_valid && (auto_rd || (tick_rd && tick))) begin
      if (q.size() == 0) chk("unexpected_pop", {out_ext, out_brk, dato}, 0);
      else chk("head", {out_ext, out_brk, dato}, q.pop_front());
      rd_en = 1'b1;
    end else rd_en = 1'b0;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] code, input logic pflip, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^code ^ pflip, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] code);
    send(code, 1'b0, PS2_FRAME_BITS);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    auto_rd = 1'b1;
    for (int i = 0; i < 300 && (fill != 0 || q.size() != 0); i++) @(negedge clk);
    chk("drain_queue", q.size(), 0);
    chk("drain_fill", fill, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_dato", dato, 0);
    chk("rst_tick", tick, 0);
    chk("rst_correct", correct, 1);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // single good frame, held in the FIFO for inspection
    t0 = ticks;
    q.push_back({2'b00, 8'h1C});
    frame(8'h1C);
    chk("f1c_ticks", ticks - t0, 1);
    chk("f1c_dato", dato, 8'h1C);
    chk("f1c_valid", out_valid, 1);
    chk("f1c_correct", correct, 1);
    chk("f1c_fill", fill, 1);
    drain();
    // bad parity
    t0 = ticks;
    send(8'h1C, 1'b1, PS2_FRAME_BITS);
    chk("par_ticks", ticks - t0, 0);
    chk("par_correct", correct, 0);
    chk("par_frame_err", frame_err, 1);
    chk("par_fill", fill, 0);
    do_reset();
    chk("par_rst_err", frame_err, 0);
    // prefix sequence
    t0 = ticks;
`ifdef PS2_EXT_DECODE_EN
    q.push_back({2'b11, 8'h75});
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("pre_ticks", ticks - t0, 1);
`else
    q.push_back({2'b00, 8'hE0});
    q.push_back({2'b00, 8'hF0});
    q.push_back({2'b00, 8'h75});
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("pre_ticks", ticks - t0, 3);
`endif
    drain();
    // partial frame times out
    send(8'h00, 1'b0, 5);
    repeat (TO + 100) @(negedge clk);
    chk("to_frame_err", frame_err, 1);
    chk("to_correct", correct, 1);
    chk("to_fill", fill, 0);
    t0 = ticks;
    q.push_back({2'b00, 8'h2A});
    frame(8'h2A);
    chk("to_next_ticks", ticks - t0, 1);
    chk("to_next_correct", correct, 1);
    drain();
    do_reset();
    // EN drop mid-frame, then sub-filter glitches
    t0 = ticks;
    send(8'h5A, 1'b0, 6);
    EN = 1'b0;
    repeat (5) @(negedge clk);
    EN = 1'b1;
    repeat (TO + 100) @(negedge clk);
    chk("en_frame_err", frame_err, 0);
    chk("en_ticks", ticks - t0, 0);
    chk("en_fill", fill, 0);
    ps2d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2c = 1'b0;
      repeat (4) @(negedge clk);
      ps2c = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
    q.push_back({2'b00, 8'h33});
    frame(8'h33);
    chk("gl_ticks", ticks - t0, 1);
    chk("gl_correct", correct, 1);
    chk("gl_frame_err", frame_err, 0);
    drain();
    do_reset();
    // overflow: nine frames into an eight-deep FIFO
    auto_rd = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) q.push_back({2'b00, 8'(i)});
      frame(8'(i));
    end
    chk("ov_fill", fill, 8);
    chk("ov_flag", overflow, 1);
    chk("ov_dato", dato, 8'h01);
    // push and pop in the same cycle while full
    q.push_back({2'b00, 8'h0A});
    tick_rd = 1'b1;
    frame(8'h0A);
    tick_rd = 1'b0;
    chk("ov_simul_fill", fill, 8);
    chk("ov_simul_head", dato, 8'h02);
    drain();
    chk("ov_out_valid", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
